// File: rtl/clock_crossing_io_arbiter.sv
// clock_crossing_io_arbiter: round-robin (or fixed-priority with CCIO_ARB_FIXED_PRIO_EN) Avalon-MM arbiter onto one bridge port, with an in-order read-ID FIFO
module clock_crossing_io_arbiter #(
  parameter int N_REQ       = 2,
  parameter int MAX_PENDING = 16
) (
  input  logic                 slave_clk,
  input  logic                 slave_reset_n,
  input  logic [N_REQ*9-1:0]   req_address,
  input  logic [N_REQ*4-1:0]   req_byteenable,
  input  logic [N_REQ-1:0]     req_read,
  input  logic [N_REQ-1:0]     req_write,
  input  logic [N_REQ*32-1:0]  req_writedata,
  output logic [N_REQ-1:0]     req_waitrequest,
  output logic [31:0]          req_readdata,
  output logic [N_REQ-1:0]     req_readdatavalid,
  output logic                 req_endofpacket,
  output logic [8:0]           br_address,
  output logic [3:0]           br_byteenable,
  output logic                 br_read,
  output logic                 br_write,
  output logic [31:0]          br_writedata,
  input  logic                 br_waitrequest,
  input  logic [31:0]          br_readdata,
  input  logic                 br_readdatavalid,
  input  logic                 br_endofpacket,
  output logic [5:0]           pending_count,
  output logic                 orphan_err
);
  localparam int IW = (N_REQ > 2) ? 2 : 1;
  localparam int PW = $clog2(MAX_PENDING);
  logic [N_REQ-1:0] active;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, lock_id_q, lock_id_d, winner, idx, start;
  logic lock_q, lock_d, orphan_err_q, orphan_err_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [5:0] count_q, count_d;
  logic [IW-1:0] fifo_q [MAX_PENDING];
  logic [IW-1:0] fifo_d [MAX_PENDING];
  logic found, rd_w, wr_w, blocked, accept, push, pop;
  assign active = req_read | req_write;
`ifdef CCIO_ARB_FIXED_PRIO_EN
  assign start = IW'(N_REQ - 1);
`else
  assign start = rr_ptr_q;
`endif
  // Scan begins just past start so the last grantee has lowest priority
  always_comb begin
    found = lock_q ? active[lock_id_q] : 1'b0;
    winner = lock_id_q;
    idx = start;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
      if (!lock_q && !found && active[idx]) begin
        found = 1'b1;
        winner = idx;
      end
    end
  end
  always_comb begin
    rd_w = found & req_read[winner];
    wr_w = found & req_write[winner] & ~req_read[winner];
    blocked = rd_w & (count_q == 6'(MAX_PENDING)) & ~br_readdatavalid;
    br_read = rd_w & ~blocked;
    br_write = wr_w;
    br_address = found ? req_address[winner*9 +: 9] : '0;
    br_byteenable = found ? req_byteenable[winner*4 +: 4] : '0;
    br_writedata = found ? req_writedata[winner*32 +: 32] : '0;
    req_waitrequest = '1;
    if (found) req_waitrequest[winner] = br_waitrequest | blocked;
    accept = (br_read | br_write) & ~br_waitrequest;
    push = br_read & ~br_waitrequest;
    pop = br_readdatavalid & (count_q != '0);
    req_readdatavalid = '0;
    if (pop) req_readdatavalid[fifo_q[rd_ptr_q]] = 1'b1;
    rr_ptr_d = accept ? winner : rr_ptr_q;
    lock_d = accept ? 1'b0 : (br_read | br_write) ? 1'b1 : lock_q;
    lock_id_d = (!accept && (br_read | br_write)) ? winner : lock_id_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + 6'(push) - 6'(pop);
    orphan_err_d = orphan_err_q | (br_readdatavalid & (count_q == '0));
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = winner;
  end
  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      rr_ptr_q <= '0;
      lock_q <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      orphan_err_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      lock_q <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      orphan_err_q <= orphan_err_d;
    end
  end
  always_ff @(posedge slave_clk) fifo_q <= fifo_d;
  assign req_readdata = br_readdata;
  assign req_endofpacket = br_endofpacket;
  assign pending_count = count_q;
  assign orphan_err = orphan_err_q;
endmodule

// File: tb/tb_clock_crossing_io_arbiter.sv
// tb_clock_crossing_io_arbiter: random masters and bridge checked against a queue-based arbitration model
module tb_clock_crossing_io_arbiter;
  localparam int N = 2;
  localparam int MP = 16;
  logic slave_clk = 1'b0;
  logic slave_reset_n;
  logic [N*9-1:0] req_address;
  logic [N*4-1:0] req_byteenable;
  logic [N-1:0] req_read, req_write, req_waitrequest, req_readdatavalid;
  logic [N*32-1:0] req_writedata;
  logic [31:0] req_readdata, br_writedata, br_readdata;
  logic req_endofpacket, br_read, br_write, br_waitrequest, br_readdatavalid, br_endofpacket, orphan_err;
  logic [8:0] br_address;
  logic [3:0] br_byteenable;
  logic [5:0] pending_count;
  clock_crossing_io_arbiter #(.N_REQ(N), .MAX_PENDING(MP)) dut (
    .slave_clk(slave_clk), .slave_reset_n(slave_reset_n),
    .req_address(req_address), .req_byteenable(req_byteenable),
    .req_read(req_read), .req_write(req_write), .req_writedata(req_writedata),
    .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
    .req_readdatavalid(req_readdatavalid), .req_endofpacket(req_endofpacket),
    .br_address(br_address), .br_byteenable(br_byteenable), .br_read(br_read),
    .br_write(br_write), .br_writedata(br_writedata), .br_waitrequest(br_waitrequest),
    .br_readdata(br_readdata), .br_readdatavalid(br_readdatavalid),
    .br_endofpacket(br_endofpacket), .pending_count(pending_count), .orphan_err(orphan_err)
  );
  always #5 slave_clk = ~slave_clk;
  typedef struct {int id; logic [31:0] d;} beat_t;
  beat_t q[$];
  bit cv[N], crd[N];
  logic [8:0] cad[N];
  logic [3:0] cbe[N];
  logic [31:0] cwd[N];
  int rr, lk_id, checks, failures;
  bit lk, orph;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_read[i] = cv[i] & crd[i];
      req_write[i] = cv[i] & ~crd[i];
      req_address[9*i +: 9] = cad[i];
      req_byteenable[4*i +: 4] = cbe[i];
      req_writedata[32*i +: 32] = cwd[i];
    end
  endtask
  task automatic do_reset();
    @(negedge slave_clk);
    slave_reset_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      cv[i] = 0;
      cad[i] = 9'($urandom_range(1, 511));
      cbe[i] = 4'($urandom);
      cwd[i] = $urandom;
    end
    drive_reqs();
    br_waitrequest = 1'b0;
    br_readdatavalid = 1'b0;
    q.delete();
    rr = 0; lk = 0; lk_id = 0; orph = 0;
    repeat (2) @(negedge slave_clk);
    slave_reset_n = 1'b1;
    #1;
    check("rst_br_read", br_read, 0);
    check("rst_br_write", br_write, 0);
    check("rst_br_address", br_address, 0);
    check("rst_br_byteenable", br_byteenable, 0);
    check("rst_br_writedata", br_writedata, 0);
    check("rst_waitrequest", req_waitrequest, {N{1'b1}});
    check("rst_rdvalid", req_readdatavalid, 0);
    check("rst_pending", pending_count, 0);
    check("rst_orphan", orphan_err, 0);
  endtask
  task automatic cycle(input int req_pct, input int wait_pct, input int rdv_pct, input bit orphan_beat);
    int w;
    bit found, blocked, brr, brw, rdv;
    logic [N-1:0] expw, expv;
    @(negedge slave_clk);
    check("pending_count", pending_count, q.size());
    check("orphan_err", orphan_err, orph);
    for (int i = 0; i < N; i++)
      if (!cv[i] && $urandom_range(0, 99) < req_pct) begin
        cv[i] = 1;
        crd[i] = 1'($urandom);
        cad[i] = 9'($urandom);
        cbe[i] = 4'($urandom);
        cwd[i] = $urandom;
      end
    drive_reqs();
    br_waitrequest = $urandom_range(0, 99) < wait_pct;
    rdv = orphan_beat || (q.size() > 0 && $urandom_range(0, 99) < rdv_pct);
    br_readdatavalid = rdv;
    br_readdata = (rdv && q.size() > 0) ? q[0].d : $urandom;
    br_endofpacket = 1'($urandom);
    found = 0;
    w = 0;
    if (lk) begin
      w = lk_id;
      found = cv[w];
    end else
      for (int k = 1; k <= N; k++) begin
        int j;
`ifdef CCIO_ARB_FIXED_PRIO_EN
        j = k - 1;
`else
        j = (rr + k) % N;
`endif
        if (!found && cv[j]) begin
          found = 1;
          w = j;
        end
      end
    blocked = found && crd[w] && q.size() == MP && !rdv;
    brr = found && crd[w] && !blocked;
    brw = found && !crd[w];
    expw = '1;
    if (found) expw[w] = br_waitrequest | blocked;
    expv = '0;
    if (rdv && q.size() > 0) expv[q[0].id] = 1'b1;
    #1;
    check("br_read", br_read, brr);
    check("br_write", br_write, brw);
    check("req_waitrequest", req_waitrequest, expw);
    check("req_readdatavalid", req_readdatavalid, expv);
    check("req_endofpacket", req_endofpacket, br_endofpacket);
    if (expv != 0) check("req_readdata", req_readdata, q[0].d);
    if (brr || brw) begin
      check("br_address", br_address, cad[w]);
      check("br_byteenable", br_byteenable, cbe[w]);
    end
    if (brw) check("br_writedata", br_writedata, cwd[w]);
    if (!found) check("idle_br_address", br_address, 0);
    if (rdv) begin
      if (q.size() > 0) void'(q.pop_front());
      else orph = 1;
    end
    if ((brr || brw) && !br_waitrequest) begin
      rr = w;
      lk = 0;
      if (brr) q.push_back('{w, $urandom});
      cv[w] = 0;
    end else if (brr || brw) begin
      lk = 1;
      lk_id = w;
    end
  endtask
  initial begin
    int n;
    checks = 0;
    failures = 0;
    do_reset();
    repeat (300) cycle(60, 30, 30, 0);
    repeat (60) cycle(80, 0, 0, 0);
    repeat (20) cycle(80, 0, 50, 0);
    repeat (300) cycle(50, 40, 40, 0);
    n = 0;
    while ((q.size() > 0 || cv[0] || cv[1]) && n < 200) begin
      cycle(0, 0, 100, 0);
      n++;
    end
    check("drain_done", q.size() == 0 && !cv[0] && !cv[1], 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    do_reset();
    repeat (10) cycle(100, 0, 0, 0);
    do_reset();
    cycle(0, 0, 0, 1);
    cycle(60, 20, 50, 0);
    repeat (100) cycle(60, 20, 50, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
